spi_ram_responder: RTL
======================

# spi_ram_responder

Simulation- and FPGA-usable SPI SRAM device model: the responder end of the SPI link that the CPU's SPI RAM controller drives as initiator. It decodes mode-0 READ (0x03) and WRITE (0x02) transactions with a 16-bit address and sequential byte streaming, and serves them from an internal byte array. A backdoor port lets the bench or board logic preload programs and inspect memory without going through SPI.

## Interface
- `ADDR_BITS`, default 16: address bits carried in the SPI frame. Must be a multiple of 8.
- `MEM_BITS`, default 8: log2 of the internal array size in bytes. Must be ≤ ADDR_BITS.
- `clk`  in  1  system clock; SPI pins are oversampled on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `spi_clk`  in  1  SPI clock from the initiator; idles low (mode 0).
- `spi_select`  in  1  chip select, active-low.
- `spi_mosi`  in  1  initiator-to-responder data, MSB first.
- `spi_miso`  out  1  responder-to-initiator data, MSB first; 0 when not driving.
- `bd_we`  in  1  backdoor write strobe.
- `bd_addr`  in  MEM_BITS  backdoor byte address.
- `bd_wdata`  in  8  backdoor write data.
- `bd_rdata`  out  8  array byte at `bd_addr`, registered, 1-cycle latency.
- `active`  out  1  high while a transaction is selected and past the command byte.
- `last_cmd`  out  8  most recently completed command byte.

## Operation
- Input sync: `spi_clk`, `spi_select`, `spi_mosi` each pass through 2 flops, plus a third flop on `spi_clk` and `spi_select` for edge detection. All decoding uses the synchronized copies only.
- Rise = `spi_clk` rising edge while select is low: shift `spi_mosi` into `shreg`, increment `bit_cnt` (3 bits).
- Fall = `spi_clk` falling edge while select is low: shift the next `spi_miso` bit out.
- FSM states: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
  - IDLE → CMD: select falling edge. Clears `bit_cnt`, address, and `spi_miso`.
  - CMD: after 8 rises, latch `last_cmd`.
    - 0x03 or 0x02 → ADDR.
    - Any other value → IGNORE.
  - ADDR: collect ADDR_BITS bits MSB first into `addr`.
    - If the command was 0x03: load `tx_byte` = mem[addr mod 2^MEM_BITS] → READ.
    - If the command was 0x02: → WRITE.
  - READ: on each fall, drive `tx_byte[7-k]`. After the 8th fall of a byte, `addr` += 1 and load the next `tx_byte`. The first data bit appears on the fall that follows the last address rise.
  - WRITE: after every 8th rise, write `shreg` to mem[addr mod 2^MEM_BITS], then `addr` += 1.
  - IGNORE: shift nothing and drive `spi_miso` = 0 until deselect.
  - Any state → IDLE on select rising edge.
- Address arithmetic: `addr` is ADDR_BITS wide and wraps 0xFFFF → 0x0000. The array index is the low MEM_BITS bits, so addresses alias modulo the array size.
- Partial byte at deselect: discarded, no write. A READ ended mid-byte has no side effect.
- `active` = state ∈ {ADDR, READ, WRITE, IGNORE}.
- Backdoor:
  - `bd_we` writes `bd_wdata` at `bd_addr` on the clock edge.
  - If the SPI write targets the same index in the same cycle, the SPI write wins.
  - `bd_rdata` reflects the array after that edge's writes.

## Timing
- Reset (async assert, sync release): state IDLE, `spi_miso` 0, `active` 0, `last_cmd` 0x00, `bd_rdata` 0x00, `bit_cnt` 0, `addr` 0. Array contents are not reset.
- Reset asserted mid-transaction aborts it; no byte is written after reset asserts. Subsequent SPI edges are ignored until the next select falling edge.
- Edge-to-action latency: 3 `clk` cycles from a pin transition to the FSM update. `spi_miso` changes 4 `clk` cycles after a `spi_clk` falling edge.
- SPI clock requirement: each `spi_clk` half-period ≥ 6 `clk` cycles. Select setup and hold to the first and last `spi_clk` edge ≥ 6 `clk` cycles. Faster SPI is unsupported.
- Write commit: array updated 1 `clk` after the rise detection that completes the byte.
- Read data: fetched from the array at the completing address rise (or byte boundary), i.e. before that byte's first bit is driven. A backdoor write to that byte after that point is not seen until the next pass.
- A select falling edge arriving while the FSM is not IDLE (no intervening rise observed) is treated as a fresh frame.

## Test plan
- Backdoor preload: 0x10=0xAB, 0x11=0xCD. SPI READ 0x03, addr 0x0010, 16 clocks. MISO yields 0xAB then 0xCD. `last_cmd`=0x03, `active` high during the frame and low after deselect.
- SPI WRITE 0x02, addr 0x0020, data 0x12 0x34, deselect. Backdoor read: 0x20=0x12, 0x21=0x34. A subsequent SPI READ at 0x0020 returns 0x1234.
- Wrap: write 0x55 0x66 at 0xFFFF. Backdoor shows 0xFF=0x55 and 0x00=0x66 (MEM_BITS=8, addr wraps to 0x0000).
- Partial byte: WRITE 0x02, addr 0x0030, 5 data bits, deselect. 0x30 keeps its preloaded 0x77.
- Unknown command 0x9F followed by 24 clocks: MISO stays 0, no array change, `last_cmd`=0x9F. The next READ frame works normally.
- Reset mid-WRITE after 3 data bits: outputs go to their reset values immediately. After release, a READ of that address returns the old value.

Source files
------------

// File: rtl/spi_ram_responder.sv
// ---------------------------------------------------------------------------
// spi_ram_responder
//
// SPI SRAM device model: the responder end of a mode-0 SPI link. It decodes
// READ (0x03) and WRITE (0x02) frames carrying an ADDR_BITS-wide address and
// then streams sequential bytes out of, or into, an internal byte array.
// A backdoor port gives direct access to the array for preloading and
// inspection without going through SPI.
//
// The SPI pins are asynchronous to clk. They are oversampled through
// two-flop synchronizers. All edge detection and decoding is done on the
// synchronized copies only.
//
// Parameters
//   ADDR_BITS  address bits carried in the SPI frame (multiple of 8)
//   MEM_BITS   log2 of the array size in bytes (<= ADDR_BITS)
//
// Ports
//   clk         system clock, SPI pins sampled on its rising edge
//   rst         asynchronous active-high reset
//   spi_clk     SPI clock from the initiator, idles low
//   spi_select  chip select, active-low
//   spi_mosi    initiator-to-responder data, MSB first
//   spi_miso    responder-to-initiator data, MSB first, 0 when not driving
//   bd_we       backdoor write strobe
//   bd_addr     backdoor byte address
//   bd_wdata    backdoor write data
//   bd_rdata    array byte at bd_addr, registered, one cycle latency
//   active      high while selected and past the command byte
//   last_cmd    most recently completed command byte
// ---------------------------------------------------------------------------
module spi_ram_responder #(
  parameter int ADDR_BITS = 16,
  parameter int MEM_BITS  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spi_clk,
  input  logic                spi_select,
  input  logic                spi_mosi,
  output logic                spi_miso,
  input  logic                bd_we,
  input  logic [MEM_BITS-1:0] bd_addr,
  input  logic [7:0]          bd_wdata,
  output logic [7:0]          bd_rdata,
  output logic                active,
  output logic [7:0]          last_cmd
);

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam int         MEM_SIZE  = 1 << MEM_BITS;
  localparam int         ADDR_BYTES = ADDR_BITS / 8;
  localparam int         ABC_W      = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam logic [ABC_W-1:0] LAST_ADDR_BYTE = ABC_W'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    READ,
    WRITE,
    IGNORE
  } state_t;

  state_t                state_q;
  logic [2:0]            sclkSync_q;
  logic [2:0]            selSync_q;
  logic [1:0]            mosiSync_q;
  logic [2:0]            bitCnt_q;
  logic [6:0]            shreg_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [ABC_W-1:0]      addrByteCnt_q;
  logic [7:0]            txByte_q;
  logic                  misoBit_q;
  logic                  spiMiso_q;
  logic [7:0]            lastCmd_q;
  logic                  active_q;
  logic                  wrEn_q;
  logic [MEM_BITS-1:0]   wrIdx_q;
  logic [7:0]            wrData_q;
  logic [7:0]            bdRdata_q;

  logic [7:0]            mem [MEM_SIZE];

  logic                  sclkSync;
  logic                  sclkPrev;
  logic                  selSync;
  logic                  selPrev;
  logic                  mosiSync;
  logic                  spiRise;
  logic                  spiFall;
  logic                  selFall;
  logic                  selRise;
  logic [7:0]            shreg_d;
  logic [ADDR_BITS-1:0]  addrShift_d;
  logic [ADDR_BITS-1:0]  addrInc_d;
  logic [7:0]            firstByte_d;
  logic [7:0]            nextByte_d;

  // Synchronizers. Stage [1] is the synchronized copy and stage [2] holds its
  // previous value for edge detection. Reset clears select to 0 rather than
  // its idle 1, so a reset released mid-frame never fakes a select falling
  // edge and the rest of that frame is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclkSync_q <= '0;
      selSync_q  <= '0;
      mosiSync_q <= '0;
    end else begin
      sclkSync_q <= {sclkSync_q[1:0], spi_clk};
      selSync_q  <= {selSync_q[1:0], spi_select};
      mosiSync_q <= {mosiSync_q[0], spi_mosi};
    end
  end

  assign sclkSync = sclkSync_q[1];
  assign sclkPrev = sclkSync_q[2];
  assign selSync  = selSync_q[1];
  assign selPrev  = selSync_q[2];
  assign mosiSync = mosiSync_q[1];

  // SPI clock edges only count while the chip is selected.
  assign spiRise = ~selSync & sclkSync & ~sclkPrev;
  assign spiFall = ~selSync & ~sclkSync & sclkPrev;
  assign selFall = ~selSync & selPrev;
  assign selRise = selSync & ~selPrev;

  // Values the FSM needs on a rise: the byte completed by the incoming bit,
  // the address with the incoming bit appended, and the following address.
  // The array is read asynchronously so the first read byte can be fetched
  // on the same edge that completes the address.
  assign shreg_d     = {shreg_q, mosiSync};
  assign addrShift_d = {addr_q[ADDR_BITS-2:0], mosiSync};
  assign addrInc_d   = addr_q + ADDR_BITS'(1);
  assign firstByte_d = mem[addrShift_d[MEM_BITS-1:0]];
  assign nextByte_d  = mem[addrInc_d[MEM_BITS-1:0]];

  // Transaction FSM. Select edges take priority over everything else. A
  // select falling edge always starts a fresh frame, even if the previous
  // frame never saw its rising edge. Completed write bytes are handed to
  // the array through a one-cycle write request, so a reset that lands
  // between the last rise and the commit cancels the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      bitCnt_q      <= '0;
      shreg_q       <= '0;
      addr_q        <= '0;
      addrByteCnt_q <= '0;
      txByte_q      <= '0;
      misoBit_q     <= 1'b0;
      lastCmd_q     <= '0;
      active_q      <= 1'b0;
      wrEn_q        <= 1'b0;
      wrIdx_q       <= '0;
      wrData_q      <= '0;
    end else begin
      wrEn_q <= 1'b0;
      if (selRise) begin
        state_q   <= IDLE;
        active_q  <= 1'b0;
        misoBit_q <= 1'b0;
      end else if (selFall) begin
        state_q       <= CMD;
        active_q      <= 1'b0;
        bitCnt_q      <= '0;
        addr_q        <= '0;
        addrByteCnt_q <= '0;
        misoBit_q     <= 1'b0;
      end else begin
        case (state_q)
          CMD: begin
            if (spiRise) begin
              shreg_q  <= shreg_d[6:0];
              bitCnt_q <= bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) begin
                lastCmd_q <= shreg_d;
                active_q  <= 1'b1;
                if ((shreg_d == CMD_READ) || (shreg_d == CMD_WRITE)) begin
                  state_q <= ADDR;
                end else begin
                  state_q <= IGNORE;
                end
              end
            end
          end
          ADDR: begin
            if (spiRise) begin
              shreg_q  <= shreg_d[6:0];
              bitCnt_q <= bitCnt_q + 3'd1;
              addr_q   <= addrShift_d;
              if (bitCnt_q == 3'd7) begin
                if (addrByteCnt_q == LAST_ADDR_BYTE) begin
                  if (lastCmd_q == CMD_READ) begin
                    txByte_q <= firstByte_d;
                    state_q  <= READ;
                  end else begin
                    state_q  <= WRITE;
                  end
                end else begin
                  addrByteCnt_q <= addrByteCnt_q + ABC_W'(1);
                end
              end
            end
          end
          READ: begin
            if (spiRise) begin
              shreg_q  <= shreg_d[6:0];
              bitCnt_q <= bitCnt_q + 3'd1;
            end
            if (spiFall) begin
              misoBit_q <= txByte_q[3'd7 - bitCnt_q];
              if (bitCnt_q == 3'd7) begin
                addr_q   <= addrInc_d;
                txByte_q <= nextByte_d;
              end
            end
          end
          WRITE: begin
            if (spiRise) begin
              shreg_q  <= shreg_d[6:0];
              bitCnt_q <= bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) begin
                wrEn_q   <= 1'b1;
                wrIdx_q  <= addr_q[MEM_BITS-1:0];
                wrData_q <= shreg_d;
                addr_q   <= addrInc_d;
              end
            end
          end
          IGNORE: begin
            misoBit_q <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Output stage for MISO. The extra register puts the pin change four
  // clk cycles after the SPI falling edge that requested it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spiMiso_q <= 1'b0;
    end else begin
      spiMiso_q <= misoBit_q;
    end
  end

  // The byte array. It is not reset. The backdoor write is applied first
  // so that an SPI write to the same index in the same cycle overrides it.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_wdata;
    end
    if (wrEn_q) begin
      mem[wrIdx_q] <= wrData_q;
    end
  end

  // Backdoor read port. It shows the array as it stands after this edge's
  // writes, following the same precedence as the array itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bdRdata_q <= '0;
    end else if (wrEn_q && (wrIdx_q == bd_addr)) begin
      bdRdata_q <= wrData_q;
    end else if (bd_we) begin
      bdRdata_q <= bd_wdata;
    end else begin
      bdRdata_q <= mem[bd_addr];
    end
  end

  assign spi_miso = spiMiso_q;
  assign bd_rdata = bdRdata_q;
  assign active   = active_q;
  assign last_cmd = lastCmd_q;

endmodule
